pc_unit: RTL and testbench

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction decoder. It holds the PC that addresses instruction memory, and it computes the next PC from the decoder's control outputs: branch, jump, jump-register, call, return, halt and I/O. It contains the hardware return-address stack used by JAL/RET. It stalls on I/O handshakes and parks the processor on HALT.

---
 rtl/pc_unit.sv | 138 +++++++++++++
 tb/tb_pc_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter, next-PC sequencing and hardware return-address stack.
// Sits ahead of the instruction decoder. It stalls on I/O handshakes and parks on HALT.
module pc_unit #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Halt,
  input  logic                           Jump_I,
  input  logic                           Jump_R,
  input  logic                           Branch,
  input  logic                           Branch_Taken,
  input  logic                           Stack_Enable,
  input  logic                           Stack_Write,
  input  logic                           IO_Enable,
  input  logic                           IO_Ready,
  input  logic                           Resume,
  input  logic [PC_WIDTH-1:0]            Imm_Addr,
  input  logic [PC_WIDTH-1:0]            Reg_Addr,
  output logic [PC_WIDTH-1:0]            PC,
  output logic                           Stall,
  output logic                           Halted,
  output logic                           Stack_Error,
  output logic [$clog2(STACK_DEPTH):0]   Stack_Count
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IO_WAIT = 2'd1,
    HALTED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [CW-1:0]       count;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic                stack_full;
  logic                stack_empty;
  logic [AW-1:0]       top_idx;
  logic [AW-1:0]       push_idx;
  logic                io_block;
  logic                jal_req;
  logic                ret_req;
  logic                do_push;

  // Shared next-PC terms and stack occupancy decode
  assign pc_inc      = PC_WIDTH'(pc + PC_WIDTH'(1));
  assign stack_full  = (count == CW'(STACK_DEPTH));
  assign stack_empty = (count == '0);
  assign top_idx     = AW'(count - CW'(1));
  assign push_idx    = AW'(count);
  assign io_block    = IO_Enable & ~IO_Ready;
  assign jal_req     = Stack_Enable & Stack_Write;
  assign ret_req     = Stack_Enable & ~Stack_Write;
  // Halt and a blocking I/O both outrank a JAL, so neither may push
  assign do_push     = (state == RUN) & ~Halt & ~io_block & jal_req & ~stack_full;

  // Return-address storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge Clock) begin
    if (do_push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  // Sequencer: state, PC and stack pointer
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      pc    <= '0;
      count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (Halt) begin
            state <= HALTED;
          end else if (io_block) begin
            state <= IO_WAIT;
          end else if (jal_req) begin
            if (stack_full) begin
              state <= ERROR;
            end else begin
              count <= CW'(count + CW'(1));
              pc    <= Imm_Addr;
            end
          end else if (ret_req) begin
            if (stack_empty) begin
              state <= ERROR;
            end else begin
              count <= CW'(count - CW'(1));
              pc    <= stack_mem[top_idx];
            end
          end else if (Jump_R) begin
            pc <= Reg_Addr;
          end else if (Jump_I) begin
            pc <= Imm_Addr;
          end else if (Branch & Branch_Taken) begin
            pc <= Imm_Addr;
          end else begin
            pc <= pc_inc;
          end
        end
        IO_WAIT: begin
          if (IO_Ready) begin
            pc    <= pc_inc;
            state <= RUN;
          end
        end
        HALTED: begin
          if (Resume) begin
            pc    <= pc_inc;
            state <= RUN;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

  // Outputs decoded straight from registered state
  assign PC          = pc;
  assign Stall       = (state == IO_WAIT);
  assign Halted      = (state == HALTED);
  assign Stack_Error = (state == ERROR);
  assign Stack_Count = count;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus random stimulus. A behavioural model predicts the
// post-edge outputs of every cycle into a queue, and a monitor pops and compares.
module tb_pc_unit;

  localparam int PW    = 10;
  localparam int DEPTH = 16;
  localparam int MODN  = 1 << PW;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Halt = 0, Jump_I = 0, Jump_R = 0, Branch = 0, Branch_Taken = 0;
  logic          Stack_Enable = 0, Stack_Write = 0, IO_Enable = 0, IO_Ready = 0, Resume = 0;
  logic [PW-1:0] Imm_Addr = '0, Reg_Addr = '0;
  logic [PW-1:0] PC;
  logic          Stall, Halted, Stack_Error;
  logic [4:0]    Stack_Count;

  pc_unit #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Halt(Halt), .Jump_I(Jump_I), .Jump_R(Jump_R),
    .Branch(Branch), .Branch_Taken(Branch_Taken), .Stack_Enable(Stack_Enable),
    .Stack_Write(Stack_Write), .IO_Enable(IO_Enable), .IO_Ready(IO_Ready),
    .Resume(Resume), .Imm_Addr(Imm_Addr), .Reg_Addr(Reg_Addr), .PC(PC),
    .Stall(Stall), .Halted(Halted), .Stack_Error(Stack_Error), .Stack_Count(Stack_Count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit rst, halt, ji, jr, br, bt, se, sw, ioe, ior, res;
    int imm, rg;
  } stim_t;

  typedef struct {
    int pc;
    bit stall, halted, err;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode names, integer PC, queue as the return stack
  typedef enum {M_RUN, M_WAIT, M_HALT, M_ERR} mode_t;
  mode_t m_mode = M_RUN;
  int    m_pc = 0;
  int    m_stk[$];

  function automatic int nxt(int a);
    return (a + 1) % MODN;
  endfunction

  task automatic model_step(input stim_t s);
    if (s.rst) begin
      m_mode = M_RUN; m_pc = 0; m_stk.delete();
      return;
    end
    case (m_mode)
      M_RUN: begin
        if (s.halt) m_mode = M_HALT;
        else if (s.ioe && !s.ior) m_mode = M_WAIT;
        else if (s.se && s.sw) begin
          if (m_stk.size() == DEPTH) m_mode = M_ERR;
          else begin m_stk.push_back(nxt(m_pc)); m_pc = s.imm; end
        end else if (s.se) begin
          if (m_stk.size() == 0) m_mode = M_ERR;
          else m_pc = m_stk.pop_back();
        end else if (s.jr) m_pc = s.rg;
        else if (s.ji) m_pc = s.imm;
        else if (s.br && s.bt) m_pc = s.imm;
        else m_pc = nxt(m_pc);
      end
      M_WAIT: if (s.ior) begin m_pc = nxt(m_pc); m_mode = M_RUN; end
      M_HALT: if (s.res) begin m_pc = nxt(m_pc); m_mode = M_RUN; end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs on the falling edge and queue the predicted result
  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge Clock);
    Reset = s.rst; Halt = s.halt; Jump_I = s.ji; Jump_R = s.jr; Branch = s.br;
    Branch_Taken = s.bt; Stack_Enable = s.se; Stack_Write = s.sw; IO_Enable = s.ioe;
    IO_Ready = s.ior; Resume = s.res; Imm_Addr = PW'(s.imm); Reg_Addr = PW'(s.rg);
    model_step(s);
    e.pc = m_pc; e.stall = (m_mode == M_WAIT); e.halted = (m_mode == M_HALT);
    e.err = (m_mode == M_ERR); e.cnt = m_stk.size();
    q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic do_reset(); stim_t s; s = idle(); s.rst = 1; apply(s); endtask
  task automatic nop(); apply(idle()); endtask
  task automatic jmp(input int a); stim_t s; s = idle(); s.ji = 1; s.imm = a; apply(s); endtask
  task automatic jal(input int a);
    stim_t s; s = idle(); s.se = 1; s.sw = 1; s.imm = a; apply(s);
  endtask
  task automatic ret(); stim_t s; s = idle(); s.se = 1; apply(s); endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compare every post-edge output against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", int'(PC), e.pc);
        chk("stall", int'(Stall), int'(e.stall));
        chk("halted", int'(Halted), int'(e.halted));
        chk("stack_error", int'(Stack_Error), int'(e.err));
        chk("stack_count", int'(Stack_Count), e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cycles;

    // Reset, then counting NOPs
    do_reset();
    repeat (5) nop();

    // Branch not taken / taken, then JR
    jmp(7);
    s = idle(); s.br = 1; s.imm = 40; apply(s);
    jmp(7);
    s = idle(); s.br = 1; s.bt = 1; s.imm = 40; apply(s);
    s = idle(); s.jr = 1; s.rg = 99; apply(s);

    // JAL / RET pair
    jmp(5);
    jal(100);
    ret();
    nop();

    // Stack overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) jal(10 * i + 20);
    jal(500);
    repeat (3) nop();
    ret();
    do_reset();
    nop();

    // Stack underflow
    ret();
    nop();
    jmp(50);
    do_reset();

    // IN stalled for four cycles
    jmp(3);
    s = idle(); s.ioe = 1; apply(s);
    repeat (3) nop();
    s = idle(); s.ior = 1; apply(s);
    nop();
    // IN completing immediately
    s = idle(); s.ioe = 1; s.ior = 1; apply(s);

    // Halt, ignore controls, resume
    jmp(9);
    s = idle(); s.halt = 1; apply(s);
    for (int i = 0; i < 10; i++) jmp(77);
    s = idle(); s.res = 1; apply(s);
    // Halt beats IO_Enable
    s = idle(); s.halt = 1; s.ioe = 1; apply(s);
    s = idle(); s.res = 1; apply(s);
    // Resume in RUN has no effect
    s = idle(); s.res = 1; apply(s);
    // Reset from IO_WAIT
    s = idle(); s.ioe = 1; apply(s);
    do_reset();

    // Wrap at the top of the address space, including the pushed return address
    jmp(MODN - 1);
    nop();
    jmp(MODN - 1);
    jal(5);
    ret();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 199) == 0);
      if (m_mode == M_ERR && $urandom_range(0, 2) == 0) s.rst = 1;
      s.halt = ($urandom_range(0, 19) == 0);
      s.ji   = ($urandom_range(0, 7) == 0);
      s.jr   = ($urandom_range(0, 7) == 0);
      s.br   = ($urandom_range(0, 3) == 0);
      s.bt   = $urandom_range(0, 1);
      s.se   = ($urandom_range(0, 4) == 0);
      s.sw   = ($urandom_range(0, 9) < 6);
      s.ioe  = ($urandom_range(0, 7) == 0);
      s.ior  = ($urandom_range(0, 2) == 0);
      s.res  = ($urandom_range(0, 3) == 0);
      s.imm  = int'($urandom_range(0, MODN - 1));
      s.rg   = int'($urandom_range(0, MODN - 1));
      apply(s);
    end

    // Drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge Clock);
      wait_cycles++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
